// File: rtl/pcie_trans_pkg.sv
// rtl/pcie_trans_pkg.sv - shared encodings for the destination drain arbiter
package pcie_trans_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    localparam int DEFAULT_BITNUMBER = 6;

endpackage

// File: rtl/drain_cnt.sv
// rtl/drain_cnt.sv - per-destination word counter; DEST_DRAIN_CNT_SAT_EN selects saturate instead of wrap
module drain_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc) begin
`ifdef DEST_DRAIN_CNT_SAT_EN
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
`else
            r_cnt <= r_cnt + CNT_ONE;
`endif
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dest_drain_arb.sv
// rtl/dest_drain_arb.sv - round-robin burst-limited drain of D0/D1 FIFOs into one tagged stream; DEST_DRAIN_CNT_SAT_EN saturates counters
module dest_drain_arb
    import pcie_trans_pkg::*;
#(
    parameter int BITNUMBER = DEFAULT_BITNUMBER,
    parameter int BURST     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 can_pop0,
    input  logic                 can_pop1,
    input  logic                 valid_in0,
    input  logic                 valid_in1,
    input  logic [BITNUMBER-1:0] data_in0,
    input  logic [BITNUMBER-1:0] data_in1,
    output logic                 pop0,
    output logic                 pop1,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 dest_out,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic                 collision
);

    localparam int            BW         = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    arb_state_t          r_state, w_state_nxt;
    logic [BW-1:0]       r_burst_cnt, w_burst_nxt;
    logic                r_last_grant, w_last_nxt;
    logic                w_pop0, w_pop1;
    logic                w_cur_id, w_cur_can, w_oth_can, w_cur_pop, w_exit;

    logic [BITNUMBER-1:0] r_data;
    logic                 r_valid;
    logic                 r_dest;
    logic                 r_collision;

    always_comb begin
        w_pop0 = (r_state == ST_GRANT0) && enable && can_pop0;
        w_pop1 = (r_state == ST_GRANT1) && enable && can_pop1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= '0;
            r_last_grant <= DEST_D1;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // On burst end the other destination wins if ready; otherwise the same one restarts a fresh burst.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_last_nxt  = r_last_grant;
        w_cur_id    = (r_state == ST_GRANT1);
        w_cur_can   = w_cur_id ? can_pop1 : can_pop0;
        w_oth_can   = w_cur_id ? can_pop0 : can_pop1;
        w_cur_pop   = w_pop0 | w_pop1;
        w_exit      = (w_cur_pop && (r_burst_cnt == BURST_LAST)) || !w_cur_can || !enable;
        case (r_state)
            ST_IDLE: begin
                if (enable && can_pop0 && ((r_last_grant == DEST_D1) || !can_pop1)) begin
                    w_state_nxt = ST_GRANT0;
                end else if (enable && can_pop1) begin
                    w_state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_exit) begin
                    w_burst_nxt = '0;
                    w_last_nxt  = w_cur_id;
                    if (enable && w_oth_can) begin
                        w_state_nxt = w_cur_id ? ST_GRANT0 : ST_GRANT1;
                    end else if (enable && w_cur_can) begin
                        w_state_nxt = r_state;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_burst_nxt = r_burst_cnt + BURST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // D0 wins a same-cycle collision; the D1 word is dropped and only flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_dest      <= DEST_D0;
            r_collision <= 1'b0;
        end else begin
            if (valid_in0) begin
                r_data  <= data_in0;
                r_dest  <= DEST_D0;
                r_valid <= 1'b1;
            end else if (valid_in1) begin
                r_data  <= data_in1;
                r_dest  <= DEST_D1;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
            if (valid_in0 && valid_in1) begin
                r_collision <= 1'b1;
            end
        end
    end

    drain_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .i_inc (valid_in0),
        .o_cnt (cnt0)
    );

    drain_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .i_inc (valid_in1 && !valid_in0),
        .o_cnt (cnt1)
    );

    assign pop0      = w_pop0;
    assign pop1      = w_pop1;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign dest_out  = r_dest;
    assign collision = r_collision;

endmodule

// File: tb/tb_dest_drain_arb.sv
// tb/tb_dest_drain_arb.sv - self-checking bench for dest_drain_arb against a behavioural model
`timescale 1ns/1ps
module tb_dest_drain_arb;

    localparam int BITNUMBER = 6;
    localparam int BURST     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
`ifdef DEST_DRAIN_CNT_SAT_EN
    localparam int EXP_CNT_260 = 255;
`else
    localparam int EXP_CNT_260 = 4;
`endif

    logic clk = 1'b0;
    logic reset, enable, can_pop0, can_pop1, valid_in0, valid_in1;
    logic [BITNUMBER-1:0] data_in0, data_in1;
    logic pop0, pop1, valid_out, dest_out, collision;
    logic [BITNUMBER-1:0] data_out;
    logic [CNT_WIDTH-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dest_drain_arb #(.BITNUMBER(BITNUMBER), .BURST(BURST), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .can_pop0(can_pop0), .can_pop1(can_pop1),
        .valid_in0(valid_in0), .valid_in1(valid_in1),
        .data_in0(data_in0), .data_in1(data_in1),
        .pop0(pop0), .pop1(pop1),
        .data_out(data_out), .valid_out(valid_out), .dest_out(dest_out),
        .cnt0(cnt0), .cnt1(cnt1), .collision(collision)
    );

    // FIFO contents seen by the DUT and observation records
    logic [BITNUMBER-1:0] q0[$], q1[$];
    logic seen_pop0 = 1'b0, seen_pop1 = 1'b0;
    int cyc = 0, n_pop0 = 0, n_valid = 0, first_v = 0, last_v = 0, first_pop = -1, tot_push = 0;
    logic obs_dest[$];
    logic [BITNUMBER-1:0] obs_data[$];

    // Behavioural model: who is being served, how many words granted in this run
    int m_owner, m_run, m_last, m_cnt0, m_cnt1;
    logic [BITNUMBER-1:0] m_data;
    logic m_valid, m_dest, m_coll;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cnt_next(input int c);
`ifdef DEST_DRAIN_CNT_SAT_EN
        return (c == CNT_MAX) ? c : c + 1;
`else
        return (c + 1) % (CNT_MAX + 1);
`endif
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        m_data = '0; m_valid = 1'b0; m_dest = 1'b0;
        m_cnt0 = 0; m_cnt1 = 0; m_coll = 1'b0;
    endfunction

    function automatic void model_advance(input logic p0, input logic p1);
        bit avail [2];
        bit took;
        avail[0] = enable && can_pop0;
        avail[1] = enable && can_pop1;
        if (m_owner < 0) begin
            if (avail[0] && (m_last == 1 || !avail[1])) m_owner = 0;
            else if (avail[1]) m_owner = 1;
        end else begin
            took = (m_owner == 0) ? p0 : p1;
            if (took && (m_run + 1 < BURST)) begin
                m_run++;
            end else begin
                m_last = m_owner;
                m_run  = 0;
                if (avail[1 - m_owner]) m_owner = 1 - m_owner;
                else if (!avail[m_owner]) m_owner = -1;
            end
        end
        if (valid_in0) begin
            m_data = data_in0; m_dest = 1'b0; m_valid = 1'b1; m_cnt0 = cnt_next(m_cnt0);
            if (valid_in1) m_coll = 1'b1;
        end else if (valid_in1) begin
            m_data = data_in1; m_dest = 1'b1; m_valid = 1'b1; m_cnt1 = cnt_next(m_cnt1);
        end else begin
            m_valid = 1'b0;
        end
    endfunction

    always @(negedge clk) begin : cmp
        logic e_pop0, e_pop1;
        cyc++;
        if (reset) model_reset();
        e_pop0 = (m_owner == 0) && enable && can_pop0;
        e_pop1 = (m_owner == 1) && enable && can_pop1;
        chk("pop0", 32'(pop0), 32'(e_pop0));
        chk("pop1", 32'(pop1), 32'(e_pop1));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("dest_out", 32'(dest_out), 32'(m_dest));
        chk("cnt0", 32'(cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(cnt1), 32'(m_cnt1));
        chk("collision", 32'(collision), 32'(m_coll));
        seen_pop0 = pop0;
        seen_pop1 = pop1;
        if (pop0) n_pop0++;
        if (first_pop < 0 && (pop0 || pop1)) first_pop = pop1 ? 1 : 0;
        if (valid_out) begin
            obs_dest.push_back(dest_out);
            obs_data.push_back(data_out);
            if (n_valid == 0) first_v = cyc;
            last_v = cyc;
            n_valid++;
        end
        if (!reset) model_advance(e_pop0, e_pop1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            valid_in0 = 1'b0;
            valid_in1 = 1'b0;
        end else begin
            valid_in0 = seen_pop0;
            if (seen_pop0) data_in0 = q0.pop_front();
            valid_in1 = seen_pop1;
            if (seen_pop1) data_in1 = q1.pop_front();
        end
        can_pop0 = (q0.size() > 0);
        can_pop1 = (q1.size() > 0);
    endtask

    task automatic push0(input int v);
        q0.push_back(BITNUMBER'(v)); can_pop0 = 1'b1; tot_push++;
    endtask

    task automatic push1(input int v);
        q1.push_back(BITNUMBER'(v)); can_pop1 = 1'b1; tot_push++;
    endtask

    task automatic clear_obs();
        obs_dest.delete(); obs_data.delete();
        n_valid = 0; n_pop0 = 0; first_pop = -1; tot_push = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) step();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic drain(input int max);
        int quiet = 0;
        enable = 1'b1;
        for (int i = 0; i < max && quiet < 4; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !valid_out && !valid_in0 && !valid_in1) quiet++;
            else quiet = 0;
        end
        chk("drain_done", 32'(quiet >= 4), 32'd1);
    endtask

    initial begin
        logic [15:0] pat;
        int j, e;
        reset = 1'b1; enable = 1'b0; can_pop0 = 1'b0; can_pop1 = 1'b0;
        valid_in0 = 1'b0; valid_in1 = 1'b0; data_in0 = '0; data_in1 = '0;
        model_reset();
        repeat (3) step();
        @(negedge clk); #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_collision", 32'(collision), 32'd0);

        // reset mid-burst on D0, then D0 must win first again
        do_reset();
        for (int k = 0; k < 6; k++) begin push0(k + 1); push1(k + 33); end
        enable = 1'b1;
        for (int i = 0; i < 50 && n_pop0 < 2; i++) step();
        reset = 1'b1;
        @(negedge clk); #1;
        chk("midrst_pop0", 32'(pop0), 32'd0);
        chk("midrst_pop1", 32'(pop1), 32'd0);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        step(); step();
        reset = 1'b0;
        clear_obs();
        for (int i = 0; i < 20 && first_pop < 0; i++) step();
        chk("first_grant_after_reset", 32'(first_pop), 32'd0);
        drain(100);

        // both FIFOs full: alternating bursts of four, back-to-back output
        do_reset();
        for (int k = 0; k < 8; k++) begin push0(k); push1(k + 8); end
        drain(100);
        pat = 16'b0000111100001111;
        chk("rr_words", 32'(n_valid), 32'd16);
        chk("rr_contiguous", 32'(last_v - first_v), 32'd15);
        for (int i = 0; i < 16 && i < obs_dest.size(); i++) begin
            j = (i / 8) * 4 + (i % 4);
            e = pat[15 - i] ? j + 8 : j;
            chk("rr_dest", 32'(obs_dest[i]), 32'(pat[15 - i]));
            chk("rr_data", 32'(obs_data[i]), 32'(e));
        end

        // only D1: burst restarts without a gap
        do_reset();
        for (int k = 0; k < 6; k++) push1(5 * k + 5);
        drain(100);
        chk("d1_words", 32'(n_valid), 32'd6);
        chk("d1_contiguous", 32'(last_v - first_v), 32'd5);
        for (int i = 0; i < 6 && i < obs_data.size(); i++) chk("d1_data", 32'(obs_data[i]), 32'(5 * i + 5));
        chk("d1_cnt1", 32'(cnt1), 32'd6);
        chk("d1_cnt0", 32'(cnt0), 32'd0);

        // enable dropped after two D0 pops
        do_reset();
        for (int k = 0; k < 5; k++) push0(k + 40);
        enable = 1'b1;
        for (int i = 0; i < 50 && n_pop0 < 2; i++) step();
        enable = 1'b0;
        repeat (6) step();
        chk("en_pops", 32'(n_pop0), 32'd2);
        chk("en_words", 32'(n_valid), 32'd2);
        chk("en_cnt0", 32'(cnt0), 32'd2);
        drain(100);
        chk("en_cnt0_final", 32'(cnt0), 32'd5);

        // forced collision
        do_reset();
        step();
        valid_in0 = 1'b1; valid_in1 = 1'b1; data_in0 = 6'h11; data_in1 = 6'h22;
        step();
        @(negedge clk); #1;
        chk("col_data", 32'(data_out), 32'h11);
        chk("col_dest", 32'(dest_out), 32'd0);
        chk("col_cnt0", 32'(cnt0), 32'd1);
        chk("col_cnt1", 32'(cnt1), 32'd0);
        chk("col_flag", 32'(collision), 32'd1);
        repeat (5) step();
        chk("col_sticky", 32'(collision), 32'd1);
        do_reset();
        @(negedge clk); #1;
        chk("col_cleared", 32'(collision), 32'd0);

        // 260 D0 words: wrap or saturate
        do_reset();
        for (int k = 0; k < 260; k++) push0(k & 63);
        drain(400);
        chk("long_words", 32'(n_valid), 32'd260);
        chk("long_cnt0", 32'(cnt0), 32'(EXP_CNT_260));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (q0.size() < 6 && $urandom_range(0, 2) == 0) push0($urandom_range(0, 63));
            if (q1.size() < 6 && $urandom_range(0, 2) == 0) push1($urandom_range(0, 63));
            enable = ($urandom_range(0, 7) != 0);
            step();
        end
        drain(200);
        chk("rand_all_delivered", 32'(n_valid), 32'(tot_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dest_drain_arb.md
Name: dest_drain_arb

Overview:
Downstream consumer of the transaction layer's two destination FIFOs (D0, D1). Drives their pop strobes with round-robin, burst-limited arbitration. Captures the words those FIFOs return into one serialized output stream tagged with destination. Keeps per-destination word counters for link statistics.

Parameters:
BITNUMBER, 6, data word width; matches transaction-layer FIFOs.
BURST, 4, max consecutive pops granted to one destination before yielding (>=1).
CNT_WIDTH, 8, width of each per-destination word counter.

Ports:
clk  input  1  single clock; all state on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
enable  input  1  arbitration enable; low = no new pops.
can_pop0  input  1  D0 FIFO holds >=1 word.
can_pop1  input  1  D1 FIFO holds >=1 word.
valid_in0  input  1  D0 FIFO read data valid (one cycle after pop0).
valid_in1  input  1  D1 FIFO read data valid (one cycle after pop1).
data_in0  input  BITNUMBER  D0 FIFO read data.
data_in1  input  BITNUMBER  D1 FIFO read data.
pop0  output  1  pop strobe to D0 FIFO (combinational).
pop1  output  1  pop strobe to D1 FIFO (combinational).
data_out  output  BITNUMBER  captured word.
valid_out  output  1  data_out valid, one-cycle pulse per word.
dest_out  output  1  source of data_out: 0=D0, 1=D1.
cnt0  output  CNT_WIDTH  words delivered from D0.
cnt1  output  CNT_WIDTH  words delivered from D1.
collision  output  1  sticky: valid_in0 and valid_in1 seen in same cycle.

Behaviour:
- Reset (async, any time incl. mid-burst): state=IDLE, burst_cnt=0, last_grant=1 (D0 wins first), data_out=0, valid_out=0, dest_out=0, cnt0=cnt1=0, collision=0. pop0=pop1=0 while reset high.
- States: IDLE, GRANT0, GRANT1.
- pop0 = (state==GRANT0) & enable & can_pop0; pop1 = (state==GRANT1) & enable & can_pop1. Never both high.
- IDLE: if enable & can_pop0 & (last_grant==1 | !can_pop1) -> GRANT0. Else if enable & can_pop1 -> GRANT1. Else stay. No pop in IDLE cycle.
- GRANTx: each pop increments burst_cnt. Exit when any of:
  - pop with burst_cnt==BURST-1
  - !can_popx
  - !enable
- On exit: burst_cnt<=0; last_grant<=x; next state=GRANTother if enable & can_pop_other, else GRANTx if enable & can_popx (burst restarts), else IDLE.
- Capture, registered: valid_in0 -> data_out<=data_in0, dest_out<=0, valid_out<=1, cnt0++. valid_in1 likewise with dest 1, cnt1++. Neither -> valid_out<=0; data_out/dest_out hold.
- Latency: pop at cycle N, valid_in at N+1, valid_out at N+2. Sustained throughput 1 word/cycle, including across grant switches.
- Simultaneous valid_in0 & valid_in1: capture D0 only, count D0 only, set collision (sticky until reset).
- Counters wrap modulo 2^CNT_WIDTH by default.
- enable drop mid-burst: pops stop the same cycle; in-flight valid_in is still captured and counted.

Optional Feature:
DEST_DRAIN_CNT_SAT_EN
- Defined: cnt0/cnt1 saturate at all-ones; no further increment.
- Undefined: counters wrap to 0.

Decomposition:
- Shared package pcie_trans_pkg: state encodings (IDLE/GRANT0/GRANT1), destination IDs (DEST_D0=0, DEST_D1=1), default BITNUMBER.
- One sub-module, drain_cnt: CNT_WIDTH counter with inc input, async active-high reset, saturate/wrap under DEST_DRAIN_CNT_SAT_EN. Instantiated twice.

Test Plan:
- Reset mid-burst (GRANT0, burst_cnt=2) -> pops drop immediately; all outputs 0; after release, D0 granted first.
- Both can_pop held high, enable=1, BURST=4 -> pop0 ×4, pop1 ×4, repeating. valid_out every cycle from N+2. dest_out pattern 0000111100001111.
- Only can_pop1 high, 6 words (0x05,0x0A,…) -> GRANT1 continuous, burst restarts after 4. data_out matches order, cnt1=6, cnt0=0.
- enable dropped after 2 pops of D0 -> pop0 low same cycle; 2 words still emitted; cnt0=2; IDLE until enable returns.
- Force valid_in0 & valid_in1 with data 0x11/0x22 -> data_out=0x11, dest_out=0, cnt0+1, cnt1 unchanged, collision=1 until reset.
- 260 D0 words, CNT_WIDTH=8 -> cnt0=4 without macro; cnt0=255 with DEST_DRAIN_CNT_SAT_EN.
